// File: rtl/eu_operand_cache_mc.sv
// Fully associative tagged operand cache: multi-port prioritised writes, 1-cycle icon reads,
// and an instruction FSM that gathers two operands and issues them to the ALU.
//
// state   | meaning
// S_IDLE  | no instruction held, instr_ready_o=1
// S_WAIT  | operand tags latched, waiting for both to be present
// S_ISSUE | operands captured and presented to ALU until accepted
module eu_operand_cache_mc #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 8,
    parameter int NUM_WCH        = 2,
    parameter bit CONSUME_ON_USE = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_WCH-1:0]          icon_wvalid_i,
    input  logic [NUM_WCH*ADDR_W-1:0]   icon_waddr_i,
    input  logic [NUM_WCH*DATA_W-1:0]   icon_wdata_i,
    output logic [NUM_WCH-1:0]          icon_wready_o,
    input  logic                        alu_wvalid_i,
    input  logic [ADDR_W-1:0]           alu_waddr_i,
    input  logic [DATA_W-1:0]           alu_wdata_i,
    output logic                        alu_wready_o,
    input  logic                        icon_rvalid_i,
    input  logic [ADDR_W-1:0]           icon_raddr_i,
    output logic                        icon_rdone_o,
    output logic                        icon_rsuccess_o,
    output logic [DATA_W-1:0]           icon_rdata_o,
    input  logic                        instr_valid_i,
    input  logic [ADDR_W-1:0]           instr_op0_addr_i,
    input  logic [ADDR_W-1:0]           instr_op1_addr_i,
    output logic                        instr_ready_o,
    output logic                        alu_op_valid_o,
    output logic [DATA_W-1:0]           alu_op0_o,
    output logic [DATA_W-1:0]           alu_op1_o,
    input  logic                        alu_op_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy_o
);
    localparam int NP    = NUM_WCH + 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

    state_t               state_q, state_n;
    logic [DEPTH-1:0]     valid_q, valid_n;
    logic [ADDR_W-1:0]    tag_q  [DEPTH];
    logic [DATA_W-1:0]    data_q [DEPTH];
    logic [ADDR_W-1:0]    op0_tag_q, op1_tag_q;

    // Port 0 is the ALU (highest priority), ports 1..NUM_WCH are icon channels in order.
    logic [NP-1:0]        wv, wready;
    logic [ADDR_W-1:0]    wtag [NP];
    logic [DATA_W-1:0]    wdat [NP];
    logic [DEPTH-1:0]     whit [NP];
    logic [DEPTH-1:0]     wen_vec [NP];

    logic [DEPTH-1:0]     rd_hit, op0_hit, op1_hit, free_mask;
    logic [DEPTH-1:0]     hit_claim, claimed, free_left, pick;
    logic                 conflict, issue_fire, latch_instr, capture_ops;
    logic [DATA_W-1:0]    rd_data, op0_data, op1_data;
    logic [OCC_W-1:0]     occ_n;

    always_comb begin
        wv[0]   = alu_wvalid_i;
        wtag[0] = alu_waddr_i;
        wdat[0] = alu_wdata_i;
        for (int c = 0; c < NUM_WCH; c++) begin
            wv[c+1]   = icon_wvalid_i[c];
            wtag[c+1] = icon_waddr_i[c*ADDR_W +: ADDR_W];
            wdat[c+1] = icon_wdata_i[c*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        rd_hit   = '0;
        op0_hit  = '0;
        op1_hit  = '0;
        rd_data  = '0;
        op0_data = '0;
        op1_data = '0;
        for (int e = 0; e < DEPTH; e++) begin
            rd_hit[e]  = valid_q[e] && (tag_q[e] == icon_raddr_i);
            op0_hit[e] = valid_q[e] && (tag_q[e] == op0_tag_q);
            op1_hit[e] = valid_q[e] && (tag_q[e] == op1_tag_q);
            for (int p = 0; p < NP; p++) begin
                whit[p][e] = valid_q[e] && (tag_q[e] == wtag[p]);
            end
            if (rd_hit[e])  rd_data  = rd_data  | data_q[e];
            if (op0_hit[e]) op0_data = op0_data | data_q[e];
            if (op1_hit[e]) op1_data = op1_data | data_q[e];
        end
    end

    assign issue_fire = (state_q == S_ISSUE) && alu_op_ready_i;

    always_comb begin
        free_mask = '0;
        if (CONSUME_ON_USE) begin
            if (icon_rvalid_i) free_mask = free_mask | rd_hit;
            if (issue_fire)    free_mask = free_mask | op0_hit | op1_hit;
        end
    end

    // Entries freed this cycle are reusable at once; entries any writer hits are never allocated.
    always_comb begin
        hit_claim = '0;
        for (int p = 0; p < NP; p++) begin
            if (wv[p]) hit_claim = hit_claim | whit[p];
        end
        claimed   = hit_claim;
        free_left = '0;
        pick      = '0;
        conflict  = 1'b0;
        for (int p = 0; p < NP; p++) begin
            conflict = 1'b0;
            for (int q = 0; q < NP; q++) begin
                if (q < p && wv[q] && (wtag[q] == wtag[p])) conflict = 1'b1;
            end
            free_left  = (~valid_q | free_mask) & ~claimed;
            pick       = free_left & (~free_left + {{(DEPTH-1){1'b0}}, 1'b1});
            wready[p]  = !conflict && ((|whit[p]) || (|free_left));
            wen_vec[p] = '0;
            if (wv[p] && wready[p]) begin
                if (|whit[p]) begin
                    wen_vec[p] = whit[p];
                end else begin
                    wen_vec[p] = pick;
                    claimed    = claimed | pick;
                end
            end
        end
    end

    assign alu_wready_o = wready[0];
    always_comb begin
        for (int c = 0; c < NUM_WCH; c++) icon_wready_o[c] = wready[c+1];
    end

    always_comb begin
        valid_n = valid_q & ~free_mask;
        for (int p = 0; p < NP; p++) valid_n = valid_n | wen_vec[p];
        occ_n = '0;
        for (int e = 0; e < DEPTH; e++) occ_n = occ_n + OCC_W'(valid_n[e]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= '0;
            occupancy_o <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                tag_q[e]  <= '0;
                data_q[e] <= '0;
            end
        end else begin
            valid_q     <= valid_n;
            occupancy_o <= occ_n;
            for (int e = 0; e < DEPTH; e++) begin
                for (int p = 0; p < NP; p++) begin
                    if (wen_vec[p][e]) begin
                        tag_q[e]  <= wtag[p];
                        data_q[e] <= wdat[p];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            icon_rdone_o    <= 1'b0;
            icon_rsuccess_o <= 1'b0;
            icon_rdata_o    <= '0;
        end else begin
            icon_rdone_o    <= icon_rvalid_i;
            icon_rsuccess_o <= icon_rvalid_i && (|rd_hit);
            icon_rdata_o    <= icon_rvalid_i ? rd_data : '0;
        end
    end

    always_comb begin
        state_n       = state_q;
        instr_ready_o = 1'b0;
        latch_instr   = 1'b0;
        capture_ops   = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) begin
                    latch_instr = 1'b1;
                    state_n     = S_WAIT;
                end
            end
            S_WAIT: begin
                if ((|op0_hit) && (|op1_hit)) begin
                    capture_ops = 1'b1;
                    state_n     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (alu_op_ready_i) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign alu_op_valid_o = (state_q == S_ISSUE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op0_tag_q <= '0;
            op1_tag_q <= '0;
            alu_op0_o <= '0;
            alu_op1_o <= '0;
        end else begin
            state_q <= state_n;
            if (latch_instr) begin
                op0_tag_q <= instr_op0_addr_i;
                op1_tag_q <= instr_op1_addr_i;
            end
            if (capture_ops) begin
                alu_op0_o <= op0_data;
                alu_op1_o <= op1_data;
            end
        end
    end
endmodule

// File: tb/tb_eu_operand_cache_mc.sv
// Directed self-checking bench for eu_operand_cache_mc with default parameters
// (DATA_W=32, ADDR_W=8, DEPTH=8, NUM_WCH=2, consume-on-use enabled).
module tb_eu_operand_cache_mc;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  icon_wvalid_i;
    logic [15:0] icon_waddr_i;
    logic [63:0] icon_wdata_i;
    logic [1:0]  icon_wready_o;
    logic        alu_wvalid_i;
    logic [7:0]  alu_waddr_i;
    logic [31:0] alu_wdata_i;
    logic        alu_wready_o;
    logic        icon_rvalid_i;
    logic [7:0]  icon_raddr_i;
    logic        icon_rdone_o;
    logic        icon_rsuccess_o;
    logic [31:0] icon_rdata_o;
    logic        instr_valid_i;
    logic [7:0]  instr_op0_addr_i;
    logic [7:0]  instr_op1_addr_i;
    logic        instr_ready_o;
    logic        alu_op_valid_o;
    logic [31:0] alu_op0_o;
    logic [31:0] alu_op1_o;
    logic        alu_op_ready_i;
    logic [3:0]  occupancy_o;

    int n_pass  = 0;
    int n_total = 0;

    eu_operand_cache_mc dut (
        .clk(clk), .reset_n(reset_n),
        .icon_wvalid_i(icon_wvalid_i), .icon_waddr_i(icon_waddr_i),
        .icon_wdata_i(icon_wdata_i), .icon_wready_o(icon_wready_o),
        .alu_wvalid_i(alu_wvalid_i), .alu_waddr_i(alu_waddr_i),
        .alu_wdata_i(alu_wdata_i), .alu_wready_o(alu_wready_o),
        .icon_rvalid_i(icon_rvalid_i), .icon_raddr_i(icon_raddr_i),
        .icon_rdone_o(icon_rdone_o), .icon_rsuccess_o(icon_rsuccess_o),
        .icon_rdata_o(icon_rdata_o),
        .instr_valid_i(instr_valid_i), .instr_op0_addr_i(instr_op0_addr_i),
        .instr_op1_addr_i(instr_op1_addr_i), .instr_ready_o(instr_ready_o),
        .alu_op_valid_o(alu_op_valid_o), .alu_op0_o(alu_op0_o),
        .alu_op1_o(alu_op1_o), .alu_op_ready_i(alu_op_ready_i),
        .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        icon_wvalid_i    = '0;
        icon_waddr_i     = '0;
        icon_wdata_i     = '0;
        alu_wvalid_i     = 1'b0;
        alu_waddr_i      = '0;
        alu_wdata_i      = '0;
        icon_rvalid_i    = 1'b0;
        icon_raddr_i     = '0;
        instr_valid_i    = 1'b0;
        instr_op0_addr_i = '0;
        instr_op1_addr_i = '0;
        alu_op_ready_i   = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] tag, input logic [31:0] d);
        icon_wvalid_i[ch]         = 1'b1;
        icon_waddr_i[ch*8 +: 8]   = tag;
        icon_wdata_i[ch*32 +: 32] = d;
    endtask

    task automatic ch0_write(input logic [7:0] tag, input logic [31:0] d);
        set_ch(0, tag, d);
        tick();
        icon_wvalid_i = '0;
    endtask

    task automatic do_read(input logic [7:0] tag);
        icon_rvalid_i = 1'b1;
        icon_raddr_i  = tag;
        tick();
        icon_rvalid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #12;
        n_total++;
        if (occupancy_o !== 4'd0) $display("FAIL rst_occ: got %0d want 0", occupancy_o);
        else n_pass++;
        n_total++;
        if (alu_op_valid_o !== 1'b0 || icon_rdone_o !== 1'b0)
            $display("FAIL rst_out: opvalid=%b rdone=%b want 0 0", alu_op_valid_o, icon_rdone_o);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_total++;
        if (instr_ready_o !== 1'b1) $display("FAIL rst_iready: got %b want 1", instr_ready_o);
        else n_pass++;
        n_total++;
        if (alu_wready_o !== 1'b1 || icon_wready_o !== 2'b11)
            $display("FAIL rst_wready: alu=%b icon=%b want 1 11", alu_wready_o, icon_wready_o);
        else n_pass++;
    endtask

    task automatic test_write_read();
        set_ch(0, 8'd5, 32'hAA);
        #1;
        n_total++;
        if (icon_wready_o[0] !== 1'b1) $display("FAIL wr_ready: got %b want 1", icon_wready_o[0]);
        else n_pass++;
        tick();
        icon_wvalid_i = '0;
        n_total++;
        if (occupancy_o !== 4'd1) $display("FAIL wr_occ: got %0d want 1", occupancy_o);
        else n_pass++;
        do_read(8'd5);
        n_total++;
        if (icon_rdone_o !== 1'b1 || icon_rsuccess_o !== 1'b1 || icon_rdata_o !== 32'hAA)
            $display("FAIL rd_hit: done=%b ok=%b data=%h want 1 1 aa",
                     icon_rdone_o, icon_rsuccess_o, icon_rdata_o);
        else n_pass++;
        n_total++;
        if (occupancy_o !== 4'd0) $display("FAIL rd_consume_occ: got %0d want 0", occupancy_o);
        else n_pass++;
        do_read(8'd9);
        n_total++;
        if (icon_rdone_o !== 1'b1 || icon_rsuccess_o !== 1'b0 || icon_rdata_o !== 32'h0)
            $display("FAIL rd_miss: done=%b ok=%b data=%h want 1 0 0",
                     icon_rdone_o, icon_rsuccess_o, icon_rdata_o);
        else n_pass++;
        tick();
        n_total++;
        if (icon_rdone_o !== 1'b0) $display("FAIL rd_idle: got %b want 0", icon_rdone_o);
        else n_pass++;
    endtask

    task automatic test_priority_full();
        for (int i = 0; i < 7; i++) ch0_write(8'(10 + i), 32'(100 + i));
        n_total++;
        if (occupancy_o !== 4'd7) $display("FAIL fill7_occ: got %0d want 7", occupancy_o);
        else n_pass++;
        alu_wvalid_i = 1'b1; alu_waddr_i = 8'd20; alu_wdata_i = 32'h2020;
        set_ch(0, 8'd21, 32'h2121);
        set_ch(1, 8'd22, 32'h2222);
        #1;
        n_total++;
        if (alu_wready_o !== 1'b1 || icon_wready_o !== 2'b00)
            $display("FAIL prio_ready: alu=%b icon=%b want 1 00", alu_wready_o, icon_wready_o);
        else n_pass++;
        tick();
        idle_inputs();
        n_total++;
        if (occupancy_o !== 4'd8) $display("FAIL prio_occ: got %0d want 8", occupancy_o);
        else n_pass++;
        do_read(8'd20);
        n_total++;
        if (icon_rsuccess_o !== 1'b1 || icon_rdata_o !== 32'h2020)
            $display("FAIL prio_rd: ok=%b data=%h want 1 2020", icon_rsuccess_o, icon_rdata_o);
        else n_pass++;
        for (int i = 0; i < 7; i++) do_read(8'(10 + i));
        n_total++;
        if (occupancy_o !== 4'd0) $display("FAIL drain_occ: got %0d want 0", occupancy_o);
        else n_pass++;
    endtask

    task automatic test_same_tag();
        alu_wvalid_i = 1'b1; alu_waddr_i = 8'd3; alu_wdata_i = 32'h11;
        set_ch(1, 8'd3, 32'h22);
        #1;
        n_total++;
        if (alu_wready_o !== 1'b1 || icon_wready_o[1] !== 1'b0)
            $display("FAIL same_tag_ready: alu=%b ch1=%b want 1 0", alu_wready_o, icon_wready_o[1]);
        else n_pass++;
        tick();
        idle_inputs();
        do_read(8'd3);
        n_total++;
        if (icon_rdata_o !== 32'h11 || occupancy_o !== 4'd0)
            $display("FAIL same_tag_rd: data=%h occ=%0d want 11 0", icon_rdata_o, occupancy_o);
        else n_pass++;
        ch0_write(8'd7, 32'h33);
        icon_rvalid_i = 1'b1; icon_raddr_i = 8'd7;
        set_ch(0, 8'd7, 32'h44);
        tick();
        idle_inputs();
        n_total++;
        if (icon_rdata_o !== 32'h33 || occupancy_o !== 4'd1)
            $display("FAIL wr_wins_pre: data=%h occ=%0d want 33 1", icon_rdata_o, occupancy_o);
        else n_pass++;
        do_read(8'd7);
        n_total++;
        if (icon_rdata_o !== 32'h44 || occupancy_o !== 4'd0)
            $display("FAIL wr_wins_post: data=%h occ=%0d want 44 0", icon_rdata_o, occupancy_o);
        else n_pass++;
    endtask

    task automatic test_instr_issue();
        instr_valid_i = 1'b1; instr_op0_addr_i = 8'd1; instr_op1_addr_i = 8'd2;
        #1;
        n_total++;
        if (instr_ready_o !== 1'b1) $display("FAIL instr_accept: got %b want 1", instr_ready_o);
        else n_pass++;
        tick();
        instr_valid_i = 1'b0;
        n_total++;
        if (instr_ready_o !== 1'b0 || alu_op_valid_o !== 1'b0)
            $display("FAIL instr_wait: ready=%b opv=%b want 0 0", instr_ready_o, alu_op_valid_o);
        else n_pass++;
        ch0_write(8'd2, 32'h200);
        ch0_write(8'd1, 32'h100);
        n_total++;
        if (alu_op_valid_o !== 1'b0) $display("FAIL issue_early: got %b want 0", alu_op_valid_o);
        else n_pass++;
        tick();
        n_total++;
        if (alu_op_valid_o !== 1'b1 || alu_op0_o !== 32'h100 || alu_op1_o !== 32'h200)
            $display("FAIL issue_ops: v=%b op0=%h op1=%h want 1 100 200",
                     alu_op_valid_o, alu_op0_o, alu_op1_o);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_ch(0, 8'd1, 32'h999);
            tick();
            icon_wvalid_i = '0;
            n_total++;
            if (alu_op_valid_o !== 1'b1 || alu_op0_o !== 32'h100 || alu_op1_o !== 32'h200)
                $display("FAIL issue_hold%0d: v=%b op0=%h op1=%h want 1 100 200",
                         i, alu_op_valid_o, alu_op0_o, alu_op1_o);
            else n_pass++;
        end
        alu_op_ready_i = 1'b1;
        tick();
        alu_op_ready_i = 1'b0;
        n_total++;
        if (alu_op_valid_o !== 1'b0 || instr_ready_o !== 1'b1 || occupancy_o !== 4'd0)
            $display("FAIL issue_done: v=%b ir=%b occ=%0d want 0 1 0",
                     alu_op_valid_o, instr_ready_o, occupancy_o);
        else n_pass++;
    endtask

    task automatic test_same_operand();
        instr_valid_i = 1'b1; instr_op0_addr_i = 8'd4; instr_op1_addr_i = 8'd4;
        tick();
        instr_valid_i = 1'b0;
        ch0_write(8'd4, 32'h44);
        tick();
        n_total++;
        if (alu_op_valid_o !== 1'b1 || alu_op0_o !== 32'h44 || alu_op1_o !== 32'h44)
            $display("FAIL same_op: v=%b op0=%h op1=%h want 1 44 44",
                     alu_op_valid_o, alu_op0_o, alu_op1_o);
        else n_pass++;
        alu_op_ready_i = 1'b1;
        tick();
        alu_op_ready_i = 1'b0;
        n_total++;
        if (occupancy_o !== 4'd0 || alu_op_valid_o !== 1'b0)
            $display("FAIL same_op_free: occ=%0d v=%b want 0 0", occupancy_o, alu_op_valid_o);
        else n_pass++;
    endtask

    task automatic test_full_stall_issue();
        instr_valid_i = 1'b1; instr_op0_addr_i = 8'd30; instr_op1_addr_i = 8'd31;
        tick();
        instr_valid_i = 1'b0;
        ch0_write(8'd30, 32'h3030);
        ch0_write(8'd31, 32'h3131);
        for (int i = 0; i < 6; i++) ch0_write(8'(40 + i), 32'(32'h4000 + i));
        n_total++;
        if (occupancy_o !== 4'd8 || alu_op_valid_o !== 1'b1)
            $display("FAIL full_state: occ=%0d v=%b want 8 1", occupancy_o, alu_op_valid_o);
        else n_pass++;
        set_ch(0, 8'd50, 32'h5050);
        set_ch(1, 8'd40, 32'h4444);
        #1;
        n_total++;
        if (icon_wready_o !== 2'b10)
            $display("FAIL full_stall: icon=%b want 10", icon_wready_o);
        else n_pass++;
        tick();
        icon_wvalid_i[1] = 1'b0;
        alu_op_ready_i = 1'b1;
        #1;
        n_total++;
        if (icon_wready_o[0] !== 1'b1) $display("FAIL free_unstall: got %b want 1", icon_wready_o[0]);
        else n_pass++;
        tick();
        idle_inputs();
        n_total++;
        if (occupancy_o !== 4'd7 || alu_op_valid_o !== 1'b0)
            $display("FAIL free_occ: occ=%0d v=%b want 7 0", occupancy_o, alu_op_valid_o);
        else n_pass++;
        do_read(8'd50);
        n_total++;
        if (icon_rdata_o !== 32'h5050 || occupancy_o !== 4'd6)
            $display("FAIL stalled_rd: data=%h occ=%0d want 5050 6", icon_rdata_o, occupancy_o);
        else n_pass++;
        do_read(8'd40);
        n_total++;
        if (icon_rdata_o !== 32'h4444) $display("FAIL hit_wr_full: got %h want 4444", icon_rdata_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid_issue();
        instr_valid_i = 1'b1; instr_op0_addr_i = 8'd41; instr_op1_addr_i = 8'd42;
        tick();
        instr_valid_i = 1'b0;
        tick();
        n_total++;
        if (alu_op_valid_o !== 1'b1 || alu_op0_o !== 32'h4001 || alu_op1_o !== 32'h4002)
            $display("FAIL pre_rst_issue: v=%b op0=%h op1=%h want 1 4001 4002",
                     alu_op_valid_o, alu_op0_o, alu_op1_o);
        else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++;
        if (alu_op_valid_o !== 1'b0 || occupancy_o !== 4'd0)
            $display("FAIL async_rst: v=%b occ=%0d want 0 0", alu_op_valid_o, occupancy_o);
        else n_pass++;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        n_total++;
        if (instr_ready_o !== 1'b1 || occupancy_o !== 4'd0 || alu_op_valid_o !== 1'b0)
            $display("FAIL post_rst: ir=%b occ=%0d v=%b want 1 0 0",
                     instr_ready_o, occupancy_o, alu_op_valid_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_priority_full();
        test_same_tag();
        test_instr_issue();
        test_same_operand();
        test_full_stall_issue();
        test_reset_mid_issue();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
